// File: rtl/sipo_word_receiver.sv
// Rebuilds parallel words from a framed serial bit stream, with optional even parity.
// Word output updates on the edge sampling its last bit; sin_valid=0 cycles stall all state.
module sipo_word_receiver #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit PARITY_EN = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin_valid,
  input  logic             sin_start,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             q_valid,
  output logic             frame_err,
  output logic             par_err
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] q_q;
  logic             q_valid_q;
  logic             frame_err_q;
  logic             par_err_q;

  logic [WIDTH-1:0] first_d;
  logic [WIDTH-1:0] shift_d;
  logic             last_data_bit;
  logic             parity_ok;

  // MSB-first shifts left into the LSB; LSB-first shifts right into the MSB,
  // so in both cases the first bit ends up at its final position after WIDTH beats.
  always_comb begin
    first_d = '0;
    shift_d = '0;
    if (MSB_FIRST) begin
      first_d[0] = sin;
      shift_d    = {sr_q[WIDTH-2:0], sin};
    end else begin
      first_d[WIDTH-1] = sin;
      shift_d          = {sin, sr_q[WIDTH-1:1]};
    end
  end

  assign last_data_bit = (cnt_q == CW'(WIDTH - 1));
  assign parity_ok     = ~(^{sr_q, sin});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sr_q        <= '0;
      q_q         <= '0;
      q_valid_q   <= 1'b0;
      frame_err_q <= 1'b0;
      par_err_q   <= 1'b0;
    end else begin
      q_valid_q   <= 1'b0;
      frame_err_q <= 1'b0;
      par_err_q   <= 1'b0;
      if (sin_valid) begin
        if (sin_start) begin
          // A start beat always opens a new frame; mid-frame it also drops the partial one.
          frame_err_q <= (state_q != IDLE);
          sr_q        <= first_d;
          cnt_q       <= CW'(1);
          state_q     <= SHIFT;
        end else begin
          case (state_q)
            SHIFT: begin
              sr_q  <= shift_d;
              cnt_q <= cnt_q + CW'(1);
              if (last_data_bit) begin
                if (PARITY_EN) begin
                  state_q <= PARITY;
                end else begin
                  q_q       <= shift_d;
                  q_valid_q <= 1'b1;
                  cnt_q     <= '0;
                  state_q   <= IDLE;
                end
              end
            end
            PARITY: begin
              if (parity_ok) begin
                q_q       <= sr_q;
                q_valid_q <= 1'b1;
              end else begin
                par_err_q <= 1'b1;
              end
              cnt_q   <= '0;
              state_q <= IDLE;
            end
            default: begin
              state_q <= IDLE;
            end
          endcase
        end
      end
    end
  end

  assign q         = q_q;
  assign q_bar     = ~q_q;
  assign q_valid   = q_valid_q;
  assign frame_err = frame_err_q;
  assign par_err   = par_err_q;

endmodule

// File: tb/tb_sipo_word_receiver.sv
// Drives three receiver configurations from one serial stream and scoreboards each against a frame-level model.
module tb_sipo_word_receiver;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sin_valid = 1'b0;
  logic sin_start = 1'b0;
  logic sin = 1'b0;

  logic [3:0] q0, qb0, q1, qb1, q2, qb2;
  logic       qv0, fe0, pe0, qv1, fe1, pe1, qv2, fe2, pe2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sipo_word_receiver #(.WIDTH(4), .MSB_FIRST(1'b1), .PARITY_EN(1'b0)) u_msb (
    .clk(clk), .rst_n(rst_n), .sin_valid(sin_valid), .sin_start(sin_start), .sin(sin),
    .q(q0), .q_bar(qb0), .q_valid(qv0), .frame_err(fe0), .par_err(pe0));
  sipo_word_receiver #(.WIDTH(4), .MSB_FIRST(1'b0), .PARITY_EN(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .sin_valid(sin_valid), .sin_start(sin_start), .sin(sin),
    .q(q1), .q_bar(qb1), .q_valid(qv1), .frame_err(fe1), .par_err(pe1));
  sipo_word_receiver #(.WIDTH(4), .MSB_FIRST(1'b1), .PARITY_EN(1'b1)) u_par (
    .clk(clk), .rst_n(rst_n), .sin_valid(sin_valid), .sin_start(sin_start), .sin(sin),
    .q(q2), .q_bar(qb2), .q_valid(qv2), .frame_err(fe2), .par_err(pe2));

  localparam logic [2:0] MSB_C = 3'b101;
  localparam logic [2:0] PAR_C = 3'b100;

  // Model state: arrival-ordered bits of the open frame, and the last accepted word.
  bit         m_in   [3];
  int         m_cnt  [3];
  logic [4:0] m_bits [3];
  logic [3:0] m_q    [3];

  logic [10:0] exp0 [$];
  logic [10:0] exp1 [$];
  logic [10:0] exp2 [$];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model(input logic r, input logic v, input logic s, input logic b);
    for (int i = 0; i < 3; i++) begin
      logic qv = 1'b0;
      logic fe = 1'b0;
      logic pe = 1'b0;
      logic [3:0] w = 4'd0;
      int need = 4 + int'(PAR_C[i]);
      if (!r) begin
        m_in[i] = 1'b0;
        m_cnt[i] = 0;
        m_q[i] = 4'd0;
      end else if (v) begin
        if (s) begin
          fe = m_in[i];
          m_in[i] = 1'b1;
          m_cnt[i] = 1;
          m_bits[i] = 5'd0;
          m_bits[i][0] = b;
        end else if (m_in[i]) begin
          m_bits[i][m_cnt[i]] = b;
          m_cnt[i]++;
          if (m_cnt[i] == need) begin
            m_in[i] = 1'b0;
            for (int k = 0; k < 4; k++) begin
              if (MSB_C[i]) w[3-k] = m_bits[i][k];
              else          w[k]   = m_bits[i][k];
            end
            if (PAR_C[i] && (^m_bits[i])) pe = 1'b1;
            else begin
              qv = 1'b1;
              m_q[i] = w;
            end
          end
        end
      end
      case (i)
        0: exp0.push_back({qv, fe, pe, m_q[i], ~m_q[i]});
        1: exp1.push_back({qv, fe, pe, m_q[i], ~m_q[i]});
        default: exp2.push_back({qv, fe, pe, m_q[i], ~m_q[i]});
      endcase
    end
  endtask

  task automatic cyc(input logic r, input logic v, input logic s, input logic b);
    @(negedge clk);
    rst_n = r;
    sin_valid = v;
    sin_start = s;
    sin = b;
    model(r, v, s, b);
  endtask

  task automatic send(input logic [7:0] seq, input int n, input bit gaps);
    for (int k = 0; k < n; k++) begin
      if (gaps) repeat ($urandom_range(0, 2)) cyc(1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, k == 0, seq[n-1-k]);
    end
  endtask

  // Monitor: one expected record per clock edge, popped and compared just after the edge.
  initial begin
    logic [10:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp0.size() > 0) begin
        e = exp0.pop_front();
        chk("sb_msb", {5'd0, qv0, fe0, pe0, q0, qb0}, {5'd0, e});
      end
      if (exp1.size() > 0) begin
        e = exp1.pop_front();
        chk("sb_lsb", {5'd0, qv1, fe1, pe1, q1, qb1}, {5'd0, e});
      end
      if (exp2.size() > 0) begin
        e = exp2.pop_front();
        chk("sb_par", {5'd0, qv2, fe2, pe2, q2, qb2}, {5'd0, e});
      end
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      m_in[i] = 1'b0;
      m_cnt[i] = 0;
      m_bits[i] = 5'd0;
      m_q[i] = 4'd0;
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);

    // Reset mid-frame after two bits of 1011.
    send(8'b10, 2, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("rst_q", {12'd0, q0}, 16'h0000);
    chk("rst_qbar", {12'd0, qb0}, 16'h000f);
    chk("rst_qvalid", {15'd0, qv0}, 16'h0000);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);

    // Stray beats without a start bit.
    repeat (3) cyc(1'b1, 1'b1, 1'b0, 1'b1);

    send(8'b1011, 4, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("basic_q", {12'd0, q0}, 16'h000b);
    chk("basic_qbar", {12'd0, qb0}, 16'h0004);
    chk("basic_qvalid", {15'd0, qv0}, 16'h0001);

    send(8'b1001, 4, 1'b1);
    send(8'b0111, 4, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("b2b_q", {12'd0, q0}, 16'h0007);

    send(8'b0111, 4, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("lsb_q", {12'd0, q1}, 16'h000e);

    send(8'b11, 2, 1'b0);
    send(8'b1111, 4, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("resync_q", {12'd0, q0}, 16'h000f);

    send(8'b10111, 5, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("par_ok_q", {12'd0, q2}, 16'h000b);
    send(8'b10011, 5, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("par_bad_pe", {15'd0, pe2}, 16'h0001);
    chk("par_bad_q", {12'd0, q2}, 16'h000b);

    // Random traffic: gaps, resyncs, parity errors and occasional resets.
    for (int n = 0; n < 1500; n++) begin
      cyc(($urandom_range(0, 199) != 0),
          ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 5) == 0),
          1'($urandom_range(0, 1)));
    end
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    chk("sb_drained", 16'(exp0.size() + exp1.size() + exp2.size()), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
